move_gen_dispatcher: RTL and testbench



---
 rtl/chess_gen_pkg.sv | 24 ++
 rtl/avalon_cmd_holder.sv | 33 +++
 rtl/move_gen_dispatcher.sv | 177 +++++++++++++++++
 tb/tb_move_gen_dispatcher.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_gen_pkg.sv
// Shared definitions for the move generator bank and its dispatcher:
// register indices, board size and the dispatcher state encoding.
package chess_gen_pkg;

    localparam logic [3:0] REG_START = 4'd0;
    localparam logic [3:0] REG_BOARD = 4'd1;
    localparam logic [3:0] REG_DEST  = 4'd2;
    localparam logic [3:0] REG_X     = 4'd3;
    localparam logic [3:0] REG_Y     = 4'd4;

    localparam int unsigned BOARD_SQUARES = 64;

    typedef enum logic [2:0] {
        StIdle,
        StWrBoard,
        StWrDest,
        StWrX,
        StWrY,
        StWrStart,
        StRdDone,
        StResult
    } disp_state_e;

endpackage

// File: rtl/avalon_cmd_holder.sv
// Single-transfer Avalon-MM master cell: presents one command while req is high and
// pulses done on the cycle the slave accepts it (waitrequest low).
module avalon_cmd_holder (
    input  logic        req,
    input  logic        rd,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic        waitrequest,
    output logic [3:0]  master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_writedata,
    output logic        done
);

    // The caller keeps req/addr/wdata constant until done, so the bus stays stable
    // across any stall without extra storage here.
    always_comb begin
        master_address   = '0;
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_writedata = '0;
        if (req) begin
            master_address   = addr;
            master_read      = rd;
            master_write     = ~rd;
            master_writedata = rd ? 32'd0 : wdata;
        end
    end

    assign done = req & ~waitrequest;

endmodule

// File: rtl/move_gen_dispatcher.sv
// Job-to-register dispatcher for a move generator control slave.
// Optional completion-read timeout enabled by defining GEN_TIMEOUT_EN.
module move_gen_dispatcher
    import chess_gen_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [31:0]      job_board_addr,
    input  logic [31:0]      job_dest_addr,
    input  logic [2:0]       job_x,
    input  logic [2:0]       job_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_count,
    output logic             res_error,
    output logic [CNT_W-1:0] total_boards,
    output logic [3:0]       master_address,
    output logic             master_read,
    output logic             master_write,
    output logic [31:0]      master_writedata,
    input  logic [31:0]      master_readdata,
    input  logic             master_waitrequest
);

    localparam int unsigned CoordW = $clog2(BOARD_SQUARES) / 2;

    disp_state_e       state_q, state_d;
    logic [31:0]       board_q, dest_q;
    logic [CoordW-1:0] x_q, y_q;
    logic [31:0]       res_count_q;
    logic [CNT_W-1:0]  total_q;

    logic              cmd_req, cmd_rd, cmd_done;
    logic [3:0]        cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              tmo_hit;

`ifdef GEN_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt_q;
    logic            res_error_q;

    assign tmo_hit = (state_q == StRdDone) && master_waitrequest &&
                     (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == StRdDone) && master_waitrequest && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign res_error = res_error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
    assign res_error      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_req   = 1'b0;
        cmd_rd    = 1'b0;
        cmd_addr  = REG_START;
        cmd_wdata = '0;
        case (state_q)
            StIdle: begin
                if (job_valid) state_d = StWrBoard;
            end
            StWrBoard: begin
                cmd_req   = 1'b1;
                cmd_addr  = REG_BOARD;
                cmd_wdata = board_q;
                if (cmd_done) state_d = StWrDest;
            end
            StWrDest: begin
                cmd_req   = 1'b1;
                cmd_addr  = REG_DEST;
                cmd_wdata = dest_q;
                if (cmd_done) state_d = StWrX;
            end
            StWrX: begin
                cmd_req   = 1'b1;
                cmd_addr  = REG_X;
                cmd_wdata = {{(32 - CoordW){1'b0}}, x_q};
                if (cmd_done) state_d = StWrY;
            end
            StWrY: begin
                cmd_req   = 1'b1;
                cmd_addr  = REG_Y;
                cmd_wdata = {{(32 - CoordW){1'b0}}, y_q};
                if (cmd_done) state_d = StWrStart;
            end
            StWrStart: begin
                cmd_req  = 1'b1;
                cmd_addr = REG_START;
                if (cmd_done) state_d = StRdDone;
            end
            StRdDone: begin
                cmd_req  = 1'b1;
                cmd_rd   = 1'b1;
                cmd_addr = REG_START;
                if (cmd_done || tmo_hit) state_d = StResult;
            end
            StResult: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            board_q <= '0;
            dest_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && job_valid) begin
                board_q <= job_board_addr;
                dest_q  <= job_dest_addr;
                x_q     <= job_x;
                y_q     <= job_y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count_q <= '0;
            total_q     <= '0;
`ifdef GEN_TIMEOUT_EN
            res_error_q <= 1'b0;
`endif
        end else if ((state_q == StRdDone) && cmd_done) begin
            res_count_q <= master_readdata;
            total_q     <= total_q + master_readdata[CNT_W-1:0];
`ifdef GEN_TIMEOUT_EN
            res_error_q <= 1'b0;
        end else if (tmo_hit) begin
            res_count_q <= '0;
            res_error_q <= 1'b1;
`endif
        end
    end

    avalon_cmd_holder u_cmd (
        .req              (cmd_req),
        .rd               (cmd_rd),
        .addr             (cmd_addr),
        .wdata            (cmd_wdata),
        .waitrequest      (master_waitrequest),
        .master_address   (master_address),
        .master_read      (master_read),
        .master_write     (master_write),
        .master_writedata (master_writedata),
        .done             (cmd_done)
    );

    assign job_ready    = (state_q == StIdle);
    assign res_valid    = (state_q == StResult);
    assign res_count    = res_count_q;
    assign total_boards = total_q;

endmodule

// File: tb/tb_move_gen_dispatcher.sv
// Randomized self-checking bench for move_gen_dispatcher with a stalling slave model.
// Define GEN_TIMEOUT_EN to also exercise the completion-read timeout.
module tb_move_gen_dispatcher;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_board_addr = '0;
    logic [31:0] job_dest_addr = '0;
    logic [2:0]  job_x = '0;
    logic [2:0]  job_y = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_count;
    logic        res_error;
    logic [15:0] total_boards;
    logic [3:0]  master_address;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_writedata;
    logic [31:0] master_readdata = '0;
    logic        master_waitrequest = 1'b0;

    move_gen_dispatcher #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .job_valid          (job_valid),
        .job_ready          (job_ready),
        .job_board_addr     (job_board_addr),
        .job_dest_addr      (job_dest_addr),
        .job_x              (job_x),
        .job_y              (job_y),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_count          (res_count),
        .res_error          (res_error),
        .total_boards       (total_boards),
        .master_address     (master_address),
        .master_read        (master_read),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_readdata    (master_readdata),
        .master_waitrequest (master_waitrequest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model state and transfer log
    int          stall_n = 0;
    bit          hang_rd = 1'b0;
    logic [31:0] rd_value = '0;
    logic [3:0]  log_addr[$];
    logic [31:0] log_data[$];
    bit          log_rd[$];

    // Reference model state
    logic [15:0] exp_total = '0;
    int          last_cons = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave: stalls each transfer stall_n cycles, logs it when accepted.
    initial begin
        int          cnt;
        logic [3:0]  s_addr;
        logic [31:0] s_data;
        logic        s_rd, s_wr;
        cnt = 0;
        s_addr = '0; s_data = '0; s_rd = 1'b0; s_wr = 1'b0;
        forever begin
            @(negedge clk);
            master_readdata = $urandom;
            if (!rst_n) begin
                cnt = 0;
                master_waitrequest = 1'b0;
            end else if (master_read || master_write) begin
                check_eq("rd_wr_excl", {63'd0, master_read & master_write}, 64'd0);
                if (cnt > 0) begin
                    check_eq("hold_addr", {60'd0, master_address}, {60'd0, s_addr});
                    check_eq("hold_data", {32'd0, master_writedata}, {32'd0, s_data});
                    check_eq("hold_rd", {63'd0, master_read}, {63'd0, s_rd});
                    check_eq("hold_wr", {63'd0, master_write}, {63'd0, s_wr});
                end else begin
                    s_addr = master_address; s_data = master_writedata;
                    s_rd = master_read; s_wr = master_write;
                end
                if ((master_read && hang_rd) || cnt < stall_n) begin
                    master_waitrequest = 1'b1;
                    cnt++;
                end else begin
                    master_waitrequest = 1'b0;
                    cnt = 0;
                    log_addr.push_back(master_address);
                    log_data.push_back(master_writedata);
                    log_rd.push_back(master_read);
                    if (master_read) master_readdata = rd_value;
                end
            end else begin
                cnt = 0;
                master_waitrequest = 1'b0;
            end
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_rd.delete();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_job_ready", {63'd0, job_ready}, 64'd1);
        check_eq("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check_eq("rst_res_count", {32'd0, res_count}, 64'd0);
        check_eq("rst_res_error", {63'd0, res_error}, 64'd0);
        check_eq("rst_total", {48'd0, total_boards}, 64'd0);
        check_eq("rst_read", {63'd0, master_read}, 64'd0);
        check_eq("rst_write", {63'd0, master_write}, 64'd0);
        check_eq("rst_addr", {60'd0, master_address}, 64'd0);
        check_eq("rst_wdata", {32'd0, master_writedata}, 64'd0);
        job_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_log();
        exp_total = '0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offer a job, follow it to its result and consume it. Called at a negedge.
    task automatic run_job(input logic [31:0] b, input logic [31:0] d, input logic [2:0] x,
                           input logic [2:0] y, input logic [31:0] rdv, input int stall,
                           input int rdly, input bit hang, input bit b2b);
        int          n, lat, rdcyc, exp_lat, nexp;
        logic [31:0] held;
        logic [3:0]  ea[6];
        logic [31:0] ed[6];
        stall_n = stall; hang_rd = hang; rd_value = rdv;
        clear_log();
        job_board_addr = b; job_dest_addr = d; job_x = x; job_y = y;
        job_valid = 1'b1;
        n = 0;
        while (!job_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("accept_timeout", 64'd0, 64'd1);
        if (b2b) check_eq("b2b_gap", 64'(cyc - last_cons), 64'd1);
        @(negedge clk);
        // Keep offering junk while busy; it must be ignored.
        job_board_addr = $urandom; job_dest_addr = $urandom;
        job_x = 3'($urandom); job_y = 3'($urandom);
        lat = 1; rdcyc = 0;
        while (!res_valid && lat < 400) begin
            if (job_ready) check_eq("busy_ready", 64'd1, 64'd0);
            if (master_read) rdcyc++;
            @(negedge clk);
            lat++;
        end
        job_valid = 1'b0;
        exp_lat = hang ? 5 * (stall + 1) + TMO + 1 : 6 * (stall + 1) + 1;
        check_eq("latency", 64'(lat), 64'(exp_lat));
        ea[0] = 4'd1; ed[0] = b;
        ea[1] = 4'd2; ed[1] = d;
        ea[2] = 4'd3; ed[2] = {29'd0, x};
        ea[3] = 4'd4; ed[3] = {29'd0, y};
        ea[4] = 4'd0; ed[4] = 32'd0;
        ea[5] = 4'd0; ed[5] = 32'd0;
        nexp = hang ? 5 : 6;
        check_eq("xfer_count", 64'(log_addr.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < log_addr.size(); i++) begin
            check_eq("xfer_addr", {60'd0, log_addr[i]}, {60'd0, ea[i]});
            check_eq("xfer_kind", {63'd0, log_rd[i]}, (i == 5) ? 64'd1 : 64'd0);
            if (i < 5) check_eq("xfer_data", {32'd0, log_data[i]}, {32'd0, ed[i]});
        end
        if (hang) begin
            check_eq("tmo_rd_cycles", 64'(rdcyc), 64'(TMO));
            held = 32'd0;
        end else begin
            held = rdv;
            exp_total = exp_total + rdv[15:0];
        end
        check_eq("res_count", {32'd0, res_count}, {32'd0, held});
        check_eq("res_error", {63'd0, res_error}, {63'd0, hang});
        check_eq("total", {48'd0, total_boards}, {48'd0, exp_total});
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            check_eq("hold_valid", {63'd0, res_valid}, 64'd1);
            check_eq("hold_count", {32'd0, res_count}, {32'd0, held});
            check_eq("result_idle_bus", {62'd0, master_read, master_write}, 64'd0);
        end
        res_ready = 1'b1;
        last_cons = cyc;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("valid_drop", {63'd0, res_valid}, 64'd0);
        check_eq("ready_back", {63'd0, job_ready}, 64'd1);
    endtask

    initial begin
        do_reset();

        // Zero-wait directed job
        run_job(32'h1000, 32'h2000, 3'd1, 3'd0, 32'd2, 0, 0, 1'b0, 1'b0);
        check_eq("total_first", {48'd0, total_boards}, 64'd2);

        // Stalling slave with a slow consumer
        run_job(32'hDEAD_BEE0, 32'h0BAD_F00D, 3'd7, 3'd5, 32'd5, 3, 5, 1'b0, 1'b0);

        // Back to back
        do_reset();
        run_job(32'h3000, 32'h4000, 3'd2, 3'd6, 32'd2, 0, 0, 1'b0, 1'b0);
        run_job(32'h5000, 32'h6000, 3'd3, 3'd4, 32'd8, 0, 0, 1'b0, 1'b1);
        check_eq("total_b2b", {48'd0, total_boards}, 64'd10);

        // Reset in the middle of WR_X
        stall_n = 0; hang_rd = 1'b0;
        job_board_addr = 32'h7000; job_dest_addr = 32'h8000; job_x = 3'd4; job_y = 3'd4;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_in_wr_x", {60'd0, master_address}, 64'd3);
        do_reset();
        run_job(32'h9000, 32'hA000, 3'd6, 3'd1, 32'd3, 1, 1, 1'b0, 1'b0);

        // Counter wrap
        do_reset();
        run_job(32'h100, 32'h200, 3'd0, 3'd7, 32'h0000_FFFF, 0, 0, 1'b0, 1'b0);
        run_job(32'h300, 32'h400, 3'd5, 3'd2, 32'd1, 0, 0, 1'b0, 1'b1);
        check_eq("total_wrap", {48'd0, total_boards}, 64'd0);

        // Randomized jobs
        for (int k = 0; k < 20; k++) begin
            run_job($urandom, $urandom, 3'($urandom), 3'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 300),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                    1'b1);
        end

`ifdef GEN_TIMEOUT_EN
        run_job(32'hC000, 32'hD000, 3'd1, 3'd1, 32'd9, $urandom_range(0, 2), 2, 1'b1, 1'b0);
        run_job(32'hE000, 32'hF000, 3'd2, 3'd3, 32'd4, 0, 0, 1'b0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
